// File: rtl/apb_master.sv
// APB requester bridging a valid/ready command/response pair onto an APB bus.
// One transfer in flight; misaligned commands fail locally; optional ACCESS timeout.
module apb_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_rsp_timeout,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [31:0] o_paddr,
  output logic [31:0] o_pwdata,
  input  logic [31:0] i_prdata,
  input  logic        i_pready,
  input  logic        i_pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_hit;

  // The wait that would make the counter reach TIMEOUT is the one that aborts.
  always_comb timeout_hit = TIMEOUT_EN && (to_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      to_cnt        <= '0;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_cmd_ready <= 1'b0;
            if (i_cmd_addr[1:0] == 2'b00) begin
              o_paddr  <= i_cmd_addr;
              o_pwrite <= i_cmd_write;
              o_pwdata <= i_cmd_write ? i_cmd_wdata : '0;
              o_psel   <= 1'b1;
              state    <= SETUP;
            end else begin
              // Misaligned: answer immediately without touching the bus.
              o_rsp_valid   <= 1'b1;
              o_rsp_err     <= 1'b1;
              o_rsp_timeout <= 1'b0;
              o_rsp_rdata   <= '0;
              state         <= RESP;
            end
          end
        end

        SETUP: begin
          o_penable <= 1'b1;
          to_cnt    <= '0;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (i_pready) begin
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_pwdata      <= '0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
            o_rsp_rdata   <= (!o_pwrite && !i_pslverr) ? i_prdata : '0;
            state         <= RESP;
          end else if (timeout_hit) begin
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            o_pwdata      <= '0;
            o_rsp_valid   <= 1'b1;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
            o_rsp_rdata   <= '0;
            state         <= RESP;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants of the bridge.
  a_penable_needs_psel: assert property (@(posedge i_clk) disable iff (i_rst)
    o_penable |-> o_psel);
  a_ready_only_idle: assert property (@(posedge i_clk) disable iff (i_rst)
    o_cmd_ready |-> (state == IDLE));
  a_no_bus_during_rsp: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_psel && o_rsp_valid));

endmodule

// File: tb/tb_apb_master.sv
// Randomized and directed bench for apb_master against a transfer-level reference model.
module tb_apb_master;

  localparam int unsigned TO      = 4;
  localparam int unsigned MAX_CYC = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_aligned = 32'h0;

  // observations of the most recent transfer
  bit          obs_start_ready, obs_ready_after, obs_hung;
  int unsigned obs_psel_n, obs_bus_bad, obs_en_bad, obs_idle_bad, obs_busy_ready;
  int unsigned obs_rsp_cyc, obs_valid_n, obs_unstable, obs_total;
  bit          obs_rsp_seen;
  logic [31:0] obs_rdata, obs_paddr_after;
  logic        obs_err, obs_to;

  always #5 clk = ~clk;

  apb_master #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_paddr(paddr), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  // Transfer-level outcome: w = ACCESS cycles the completer stalls before pready.
  function automatic void model(input logic wr, input logic [31:0] addr, input int unsigned w,
                                input logic slverr, input logic [31:0] prd,
                                output int unsigned e_psel_n, output int unsigned e_rsp_cyc,
                                output logic [31:0] e_rdata, output logic e_err,
                                output logic e_to);
    logic [1:0] lo;
    lo = addr[1:0];
    if (lo != 2'b00) begin
      e_psel_n = 0; e_rsp_cyc = 1; e_rdata = 32'h0; e_err = 1'b1; e_to = 1'b0;
    end else if (TO != 0 && w >= TO) begin
      e_psel_n = 1 + TO; e_rsp_cyc = 2 + TO; e_rdata = 32'h0; e_err = 1'b1; e_to = 1'b1;
    end else begin
      e_psel_n = 2 + w; e_rsp_cyc = 3 + w;
      e_rdata = (!wr && !slverr) ? prd : 32'h0;
      e_err = slverr; e_to = 1'b0;
    end
  endfunction

  // Drives one command from a negedge with the DUT idle; returns at the idle negedge after it.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned w, input logic slverr, input logic [31:0] prd,
                          input int unsigned hold);
    int unsigned acc, cyc;
    bit          done;
    logic [31:0] exp_pwdata;
    exp_pwdata = wr ? wdata : 32'h0;
    obs_start_ready = cmd_ready;
    obs_psel_n = 0; obs_bus_bad = 0; obs_en_bad = 0; obs_idle_bad = 0; obs_busy_ready = 0;
    obs_rsp_cyc = 0; obs_valid_n = 0; obs_unstable = 0; obs_rsp_seen = 1'b0;
    obs_rdata = 32'h0; obs_err = 1'b0; obs_to = 1'b0; obs_ready_after = 1'b0;
    obs_paddr_after = 32'h0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    acc = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = $urandom; cmd_wdata = $urandom;
      if (psel) begin
        obs_psel_n++;
        if (paddr !== addr || pwrite !== wr || pwdata !== exp_pwdata) obs_bus_bad++;
        if (penable !== (obs_psel_n != 1)) obs_en_bad++;
      end else if (penable !== 1'b0 || pwdata !== 32'h0) begin
        obs_idle_bad++;
      end
      if (cmd_ready && !(obs_rsp_seen && !rsp_valid)) obs_busy_ready++;
      if (psel && penable) begin
        if (acc == w) begin
          pready = 1'b1; pslverr = slverr; prdata = prd;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
        acc++;
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
      if (rsp_valid) begin
        if (!obs_rsp_seen) begin
          obs_rsp_seen = 1'b1; obs_rsp_cyc = cyc;
          obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
        end else if (rsp_rdata !== obs_rdata || rsp_err !== obs_err || rsp_timeout !== obs_to) begin
          obs_unstable++;
        end
        obs_valid_n++;
        rsp_ready = (obs_valid_n > hold);
      end else if (obs_rsp_seen) begin
        done = 1'b1;
        obs_ready_after = cmd_ready;
        obs_paddr_after = paddr;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = 1'($urandom);
      end
    end
    obs_total = cyc;
    obs_hung = !done;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    #3;
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
    end
    n_checks++;
    if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, expected all zero",
               paddr, pwdata, rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    run_xfer(1'b1, 32'h4000_2004, 32'hDEAD_BEEF, 0, 1'b0, 32'hA5A5_5A5A, 0);
    last_aligned = 32'h4000_2004;
    n_checks++;
    if (obs_psel_n !== 2 || obs_bus_bad !== 0 || obs_en_bad !== 0) begin
      n_fail++;
      $display("FAIL write_bus: got psel_n=%0d bus_bad=%0d en_bad=%0d, expected 2/0/0",
               obs_psel_n, obs_bus_bad, obs_en_bad);
    end
    n_checks++;
    if ({obs_err, obs_to, obs_rdata} !== 34'h0 || obs_rsp_cyc !== 3) begin
      n_fail++;
      $display("FAIL write_rsp: got err=%b to=%b rdata=%h cyc=%0d, expected 0/0/0/3",
               obs_err, obs_to, obs_rdata, obs_rsp_cyc);
    end
  endtask

  task automatic test_read_wait();
    run_xfer(1'b0, 32'h4000_2008, 32'h1111_2222, 3, 1'b0, 32'h1234_5678, 0);
    last_aligned = 32'h4000_2008;
    n_checks++;
    if (obs_psel_n !== 5 || obs_bus_bad !== 0 || obs_idle_bad !== 0) begin
      n_fail++;
      $display("FAIL read_wait_bus: got psel_n=%0d bus_bad=%0d idle_bad=%0d, expected 5/0/0",
               obs_psel_n, obs_bus_bad, obs_idle_bad);
    end
    n_checks++;
    if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0 || obs_to !== 1'b0) begin
      n_fail++;
      $display("FAIL read_wait_rsp: got rdata=%h err=%b to=%b, expected 12345678/0/0",
               obs_rdata, obs_err, obs_to);
    end
    n_checks++;
    if (obs_paddr_after !== 32'h4000_2008) begin
      n_fail++;
      $display("FAIL read_paddr_hold: got %h, expected 40002008", obs_paddr_after);
    end
  endtask

  task automatic test_slverr();
    run_xfer(1'b0, 32'h4000_2020, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 0);
    last_aligned = 32'h4000_2020;
    n_checks++;
    if (obs_err !== 1'b1 || obs_to !== 1'b0 || obs_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL slverr_rsp: got err=%b to=%b rdata=%h, expected 1/0/0",
               obs_err, obs_to, obs_rdata);
    end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h4000_2030, 32'h0, 50, 1'b0, 32'h5555_AAAA, 0);
    last_aligned = 32'h4000_2030;
    n_checks++;
    if (obs_psel_n !== 1 + TO || obs_rsp_cyc !== 2 + TO) begin
      n_fail++;
      $display("FAIL timeout_len: got psel_n=%0d rsp_cyc=%0d, expected %0d/%0d",
               obs_psel_n, obs_rsp_cyc, 1 + TO, 2 + TO);
    end
    n_checks++;
    if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_rsp: got err=%b to=%b rdata=%h, expected 1/1/0",
               obs_err, obs_to, obs_rdata);
    end
    // pready arriving in the last permitted ACCESS cycle must complete normally
    run_xfer(1'b0, 32'h4000_2034, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE, 0);
    last_aligned = 32'h4000_2034;
    n_checks++;
    if (obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_CAFE || obs_psel_n !== 1 + TO) begin
      n_fail++;
      $display("FAIL timeout_edge: got to=%b err=%b rdata=%h psel_n=%0d, expected 0/0/0badcafe/%0d",
               obs_to, obs_err, obs_rdata, obs_psel_n, 1 + TO);
    end
  endtask

  task automatic test_misaligned();
    run_xfer(1'b1, 32'h4000_2006, 32'h7777_7777, 0, 1'b0, 32'h0, 0);
    n_checks++;
    if (obs_psel_n !== 0 || obs_rsp_cyc !== 1) begin
      n_fail++;
      $display("FAIL misaligned_bus: got psel_n=%0d rsp_cyc=%0d, expected 0/1", obs_psel_n, obs_rsp_cyc);
    end
    n_checks++;
    if (obs_err !== 1'b1 || obs_to !== 1'b0 || obs_rdata !== 32'h0 || obs_paddr_after !== last_aligned) begin
      n_fail++;
      $display("FAIL misaligned_rsp: got err=%b to=%b rdata=%h paddr=%h, expected 1/0/0/%h",
               obs_err, obs_to, obs_rdata, obs_paddr_after, last_aligned);
    end
  endtask

  task automatic test_rsp_hold();
    run_xfer(1'b0, 32'h4000_2040, 32'h0, 1, 1'b0, 32'h3C3C_C3C3, 5);
    last_aligned = 32'h4000_2040;
    n_checks++;
    if (obs_valid_n !== 6 || obs_unstable !== 0 || obs_busy_ready !== 0) begin
      n_fail++;
      $display("FAIL rsp_hold: got valid_n=%0d unstable=%0d busy_ready=%0d, expected 6/0/0",
               obs_valid_n, obs_unstable, obs_busy_ready);
    end
    n_checks++;
    if (obs_rdata !== 32'h3C3C_C3C3 || obs_ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_hold_data: got rdata=%h ready_after=%b, expected 3c3cc3c3/1",
               obs_rdata, obs_ready_after);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      run_xfer(1'(i), 32'h4000_3000 + 32'(i * 4), $urandom, 0, 1'b0, $urandom, 0);
      last_aligned = 32'h4000_3000 + 32'(i * 4);
      n_checks++;
      if (obs_start_ready !== 1'b1 || obs_total !== 4 || obs_hung) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got start_ready=%b cycles=%0d, expected 1/4",
                 i, obs_start_ready, obs_total);
      end
    end
  endtask

  task automatic test_random();
    logic        wr, sl;
    logic [31:0] a, wd, prd, e_rdata, e_paddr;
    int unsigned w, hold, e_psel_n, e_rsp_cyc;
    logic        e_err, e_to;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); sl = 1'($urandom); wd = $urandom; prd = $urandom;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w = $urandom_range(0, 6); hold = $urandom_range(0, 3);
      model(wr, a, w, sl, prd, e_psel_n, e_rsp_cyc, e_rdata, e_err, e_to);
      e_paddr = (a[1:0] == 2'b00) ? a : last_aligned;
      run_xfer(wr, a, wd, w, sl, prd, hold);
      last_aligned = e_paddr;
      n_checks++;
      if (obs_hung || obs_rdata !== e_rdata || obs_err !== e_err || obs_to !== e_to) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got hung=%b rdata=%h err=%b to=%b, expected 0/%h/%b/%b",
                 i, obs_hung, obs_rdata, obs_err, obs_to, e_rdata, e_err, e_to);
      end
      n_checks++;
      if (obs_psel_n !== e_psel_n || obs_rsp_cyc !== e_rsp_cyc || obs_valid_n !== hold + 1) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: got psel_n=%0d rsp_cyc=%0d valid_n=%0d, expected %0d/%0d/%0d",
                 i, obs_psel_n, obs_rsp_cyc, obs_valid_n, e_psel_n, e_rsp_cyc, hold + 1);
      end
      n_checks++;
      if (obs_bus_bad + obs_en_bad + obs_idle_bad + obs_busy_ready + obs_unstable != 0
          || obs_ready_after !== 1'b1 || obs_paddr_after !== e_paddr) begin
        n_fail++;
        $display("FAIL rand_proto[%0d]: got bus=%0d en=%0d idle=%0d busy=%0d unst=%0d rdy=%b paddr=%h, expected zeros/1/%h",
                 i, obs_bus_bad, obs_en_bad, obs_idle_bad, obs_busy_ready, obs_unstable,
                 obs_ready_after, obs_paddr_after, e_paddr);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int unsigned rsp_seen_n, psel_seen_n;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_2010; cmd_wdata = 32'h1357_9BDF;
    pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got psel=%b penable=%b, expected 1/1", psel, penable);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({psel, penable, rsp_valid} !== 3'b0 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got psel=%b penable=%b rsp_valid=%b paddr=%h pwdata=%h, expected all zero",
               psel, penable, rsp_valid, paddr, pwdata);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_seen_n = 0; psel_seen_n = 0;
    for (int i = 0; i < 6; i++) begin
      pready = 1'($urandom); rsp_ready = 1'b1;
      @(negedge clk);
      if (rsp_valid) rsp_seen_n++;
      if (psel) psel_seen_n++;
    end
    n_checks++;
    if (rsp_seen_n != 0 || psel_seen_n != 0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_after: got rsp_cycles=%0d psel_cycles=%0d cmd_ready=%b, expected 0/0/1",
               rsp_seen_n, psel_seen_n, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_misaligned();
    test_rsp_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; the number of consecutive ACCESS cycles without i_pready before abort; 0 disables the timeout.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_cmd_valid  input  1  command request.
REQ-005 SHALL have port o_cmd_ready  output  1  command accepted when i_cmd_valid and o_cmd_ready are both high.
REQ-006 SHALL have port i_cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port i_cmd_addr  input  32  byte address.
REQ-008 SHALL have port i_cmd_wdata  input  32  write data.
REQ-009 SHALL have port o_rsp_valid  output  1  response available.
REQ-010 SHALL have port i_rsp_ready  input  1  response consumed when o_rsp_valid and i_rsp_ready are both high.
REQ-011 SHALL have port o_rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port o_rsp_err  output  1  transfer failed (pslverr, misalignment or timeout).
REQ-013 SHALL have port o_rsp_timeout  output  1  failure caused by timeout.
REQ-014 SHALL have ports o_psel, o_penable, o_pwrite (output 1), o_paddr, o_pwdata (output 32); APB request signals.
REQ-015 SHALL have ports i_prdata (input 32), i_pready, i_pslverr (input 1); APB completer response.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-017 o_cmd_ready SHALL be high only in IDLE; at most one transfer in flight.
REQ-018 On accept with i_cmd_addr[1:0]==0: latch addr, wdata, write into registers; next state SETUP.
REQ-019 On accept with i_cmd_addr[1:0]!=0: no APB activity; next state RESP with err=1, timeout=0, rdata=0.
REQ-020 SETUP SHALL last exactly one cycle with o_psel=1, o_penable=0; next state ACCESS.
REQ-021 ACCESS SHALL drive o_psel=1, o_penable=1 and hold until i_pready=1 is sampled or the timeout fires.
REQ-022 o_paddr, o_pwrite and o_pwdata SHALL be stable from SETUP through the last ACCESS cycle; o_pwdata=0 for reads.
REQ-023 Outside SETUP/ACCESS: o_psel=0, o_penable=0; o_paddr and o_pwrite hold the last value; o_pwdata=0.
REQ-024 On i_pready=1 in ACCESS: o_rsp_err is set to i_pslverr; o_rsp_rdata is set to i_prdata for a read with pslverr=0, else 0; next state RESP.
REQ-025 i_pslverr and i_prdata SHALL be ignored unless sampled in ACCESS with i_pready=1.
REQ-026 Timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with i_pready=0.
REQ-027 When the counter reaches TIMEOUT (TIMEOUT>0) with i_pready still 0: err=1, timeout=1, rdata=0; o_psel drops next cycle; next state RESP.
REQ-028 If i_pready=1 in the same cycle the counter reaches TIMEOUT, the completion SHALL win and no timeout is reported.
REQ-029 In RESP, o_rsp_valid=1 and the response fields SHALL be held stable until i_rsp_ready=1; then next state IDLE.
REQ-030 Minimum latency SHALL be 4 cycles per transfer (IDLE, SETUP, ACCESS, RESP) with i_pready=1 and i_rsp_ready=1 held high.

Reset
REQ-031 Asserting i_rst SHALL immediately force state IDLE.
REQ-032 Asserting i_rst SHALL immediately drive o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err and o_rsp_timeout to 0.
REQ-033 Asserting i_rst SHALL immediately drive o_paddr, o_pwdata and o_rsp_rdata to 0 and clear the timeout counter.
REQ-034 o_cmd_ready SHALL be 1 in the first cycle after i_rst deasserts.
REQ-035 Reset during SETUP, ACCESS or RESP SHALL abandon the transfer with no response generated.

Verification
REQ-036 Write 0x40002004/0xDEADBEEF, i_pready=1 -> SETUP cycle then one ACCESS cycle with paddr and pwdata stable; rsp err=0, rdata=0.
REQ-037 Read 0x40002008, i_pready low for 3 ACCESS cycles then high with prdata=0x12345678 -> rsp rdata=0x12345678, err=0; psel high for 5 cycles.
REQ-038 Read 0x40002020 with pready=1, pslverr=1 -> rsp err=1, timeout=0, rdata=0.
REQ-039 TIMEOUT=4, i_pready stuck 0 -> after 4 ACCESS cycles psel drops; rsp err=1, timeout=1.
REQ-040 Command addr 0x40002006 -> psel never asserts; rsp err=1 the next cycle.
REQ-041 i_rsp_ready held 0 for 5 cycles -> response held stable and o_cmd_ready=0; i_rst pulse mid-ACCESS -> psel=0 immediately and no response appears.
